// File: rtl/arith_stim_check_if.sv
// Operand/result bus between the arith stimulus checker (master) and the arithmetic DUT (slave).
interface arith_stim_check_if;
  logic signed [8:0] eta_o1_a;
  logic signed [8:0] eta_o1_b;
  logic              vld_o;
  logic signed [8:0] topLet_i;

  modport master (output eta_o1_a, output eta_o1_b, output vld_o, input topLet_i);
  modport slave  (input eta_o1_a, input eta_o1_b, input vld_o, output topLet_i);
endinterface

// File: rtl/arith_stim_check.sv
// LFSR-driven stimulus generator and adder result checker for a 9-bit signed DUT.
// Optional first-mismatch capture ports: define ARITH_STIM_CHECK_FIRSTFAIL_EN.
module arith_stim_check #(
  parameter int          NUM_VECTORS = 64,
  parameter int          DUT_LATENCY = 1,
  parameter logic [17:0] SEED        = 18'h000A5
) (
  input  logic               system1000,
  input  logic               system1000_rst,
  input  logic               start,
  arith_stim_check_if.master bus,
  output logic               done,
  output logic               pass,
  output logic [7:0]         err_count
`ifdef ARITH_STIM_CHECK_FIRSTFAIL_EN
  ,
  output logic [7:0]         first_fail_idx,
  output logic [8:0]         first_fail_got,
  output logic [8:0]         first_fail_exp
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  localparam logic [17:0] SEED_EFF   = (SEED == 18'h00000) ? 18'h00001 : SEED;
  localparam logic [7:0]  LAST_VEC   = 8'(NUM_VECTORS - 1);
  localparam logic [2:0]  LAST_DRAIN = (DUT_LATENCY == 0) ? 3'd0 : 3'(DUT_LATENCY - 1);

  // Right-shifting Galois form of x^18 + x^11 + 1.
  function automatic logic [17:0] lfsr_step(input logic [17:0] cur);
    lfsr_step = {1'b0, cur[17:1]} ^ (cur[0] ? 18'h20400 : 18'h00000);
  endfunction

  state_t      state_r;
  logic [17:0] lfsr_r;
  logic [17:0] lfsr_next_s;
  logic [7:0]  vec_cnt_r;
  logic [2:0]  drain_cnt_r;
  logic [8:0]  a_r;
  logic [8:0]  b_r;
  logic        vld_r;
  logic        done_r;
  logic        pass_r;
  logic [7:0]  err_r;
  logic [7:0]  err_next_s;
  logic [8:0]  sum_s;
  logic        start_run_s;
  logic        dly_vld_s;
  logic [8:0]  dly_exp_s;
  logic        mismatch_s;

  assign bus.eta_o1_a = a_r;
  assign bus.eta_o1_b = b_r;
  assign bus.vld_o    = vld_r;
  assign done         = done_r;
  assign pass         = pass_r;
  assign err_count    = err_r;

  // Next LFSR value, expected sum and saturating mismatch count.
  always_comb begin
    lfsr_next_s = lfsr_step(lfsr_r);
    sum_s       = a_r + b_r;
    start_run_s = start && ((state_r == IDLE) || (state_r == DONE));
    mismatch_s  = dly_vld_s && ($unsigned(bus.topLet_i) != dly_exp_s);
    if (mismatch_s && (err_r != 8'hFF)) begin
      err_next_s = err_r + 8'd1;
    end else begin
      err_next_s = err_r;
    end
  end

  // Run sequencer; operands, done and pass are registered alongside the state.
  always_ff @(posedge system1000 or negedge system1000_rst) begin
    if (!system1000_rst) begin
      state_r     <= IDLE;
      lfsr_r      <= SEED_EFF;
      vec_cnt_r   <= 8'd0;
      drain_cnt_r <= 3'd0;
      a_r         <= 9'd0;
      b_r         <= 9'd0;
      vld_r       <= 1'b0;
      err_r       <= 8'd0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
    end else if (start_run_s) begin
      state_r     <= RUN;
      lfsr_r      <= SEED_EFF;
      vec_cnt_r   <= 8'd0;
      drain_cnt_r <= 3'd0;
      a_r         <= SEED_EFF[17:9];
      b_r         <= SEED_EFF[8:0];
      vld_r       <= 1'b1;
      err_r       <= 8'd0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          err_r  <= err_next_s;
          lfsr_r <= lfsr_next_s;
          if (vec_cnt_r == LAST_VEC) begin
            a_r   <= 9'd0;
            b_r   <= 9'd0;
            vld_r <= 1'b0;
            if (DUT_LATENCY == 0) begin
              state_r <= DONE;
              done_r  <= 1'b1;
              pass_r  <= (err_next_s == 8'd0);
            end else begin
              state_r     <= DRAIN;
              drain_cnt_r <= 3'd0;
            end
          end else begin
            vec_cnt_r <= vec_cnt_r + 8'd1;
            a_r       <= lfsr_next_s[17:9];
            b_r       <= lfsr_next_s[8:0];
          end
        end
        DRAIN: begin
          err_r <= err_next_s;
          if (drain_cnt_r == LAST_DRAIN) begin
            state_r <= DONE;
            done_r  <= 1'b1;
            pass_r  <= (err_next_s == 8'd0);
          end else begin
            drain_cnt_r <= drain_cnt_r + 3'd1;
          end
        end
        IDLE, DONE: begin
          state_r <= state_r;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

`ifdef ARITH_STIM_CHECK_FIRSTFAIL_EN
  logic [7:0] dly_idx_s;
`endif

  // Expected value travels with its valid so it lines up with the DUT result.
  generate
    if (DUT_LATENCY == 0) begin : g_no_dly
      assign dly_vld_s = vld_r;
      assign dly_exp_s = sum_s;
`ifdef ARITH_STIM_CHECK_FIRSTFAIL_EN
      assign dly_idx_s = vec_cnt_r;
`endif
    end else begin : g_dly
      logic [DUT_LATENCY-1:0] vld_pipe_r;
      logic [8:0]             exp_pipe_r [DUT_LATENCY];
`ifdef ARITH_STIM_CHECK_FIRSTFAIL_EN
      logic [7:0]             idx_pipe_r [DUT_LATENCY];
`endif
      // Shift register of (valid, expected[, index]) cleared by reset.
      always_ff @(posedge system1000 or negedge system1000_rst) begin
        if (!system1000_rst) begin
          vld_pipe_r <= '0;
          for (int i = 0; i < DUT_LATENCY; i++) begin
            exp_pipe_r[i] <= 9'd0;
`ifdef ARITH_STIM_CHECK_FIRSTFAIL_EN
            idx_pipe_r[i] <= 8'd0;
`endif
          end
        end else begin
          vld_pipe_r[0] <= vld_r;
          exp_pipe_r[0] <= sum_s;
`ifdef ARITH_STIM_CHECK_FIRSTFAIL_EN
          idx_pipe_r[0] <= vec_cnt_r;
`endif
          for (int i = 1; i < DUT_LATENCY; i++) begin
            vld_pipe_r[i] <= vld_pipe_r[i-1];
            exp_pipe_r[i] <= exp_pipe_r[i-1];
`ifdef ARITH_STIM_CHECK_FIRSTFAIL_EN
            idx_pipe_r[i] <= idx_pipe_r[i-1];
`endif
          end
        end
      end
      assign dly_vld_s = vld_pipe_r[DUT_LATENCY-1];
      assign dly_exp_s = exp_pipe_r[DUT_LATENCY-1];
`ifdef ARITH_STIM_CHECK_FIRSTFAIL_EN
      assign dly_idx_s = idx_pipe_r[DUT_LATENCY-1];
`endif
    end
  endgenerate

`ifdef ARITH_STIM_CHECK_FIRSTFAIL_EN
  logic       ff_seen_r;
  logic [7:0] ff_idx_r;
  logic [8:0] ff_got_r;
  logic [8:0] ff_exp_r;

  assign first_fail_idx = ff_idx_r;
  assign first_fail_got = ff_got_r;
  assign first_fail_exp = ff_exp_r;

  // Latch index, DUT value and expected value of the first mismatch in a run.
  always_ff @(posedge system1000 or negedge system1000_rst) begin
    if (!system1000_rst) begin
      ff_seen_r <= 1'b0;
      ff_idx_r  <= 8'd0;
      ff_got_r  <= 9'd0;
      ff_exp_r  <= 9'd0;
    end else if (start_run_s) begin
      ff_seen_r <= 1'b0;
      ff_idx_r  <= 8'd0;
      ff_got_r  <= 9'd0;
      ff_exp_r  <= 9'd0;
    end else if (mismatch_s && !ff_seen_r) begin
      ff_seen_r <= 1'b1;
      ff_idx_r  <= dly_idx_s;
      ff_got_r  <= bus.topLet_i;
      ff_exp_r  <= dly_exp_s;
    end
  end
`endif

endmodule
